// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad matrix and the scanner: row sense in;
// column drive and decoded key outputs out.
interface keypad_scanner_if;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       key_held_o;

    modport master (
        output row_i,
        input  col_o,
        input  key_o,
        input  key_valid_o,
        input  key_held_o
    );

    modport slave (
        input  row_i,
        output col_o,
        output key_o,
        output key_valid_o,
        output key_held_o
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: walks one column low at a time, debounces whole-matrix
// frames and reports one accepted key with a one-cycle strobe and a held level.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 256,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic               clock2,
    input  logic               reset,
    keypad_scanner_if.slave    kbus
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;
    logic [1:0]    col_q;
    logic [3:0]    sync1_q, sync2_q;
    logic [15:0]   snap_q;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic          sample;
    logic          frame_end;
    logic [15:0]   merged;
    logic [4:0]    ones;
    logic [3:0]    idx;
    logic          none;
    logic          single;
    logic [CW-1:0] cnt_inc;

    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (col_q == 2'd3);
    // Column 3 is classified on the same edge it is sampled, so its bits bypass snap_q.
    assign merged    = {~sync2_q, snap_q[11:0]};

    assign kbus.col_o       = ~(4'b0001 << col_q);
    assign kbus.key_o       = key_q;
    assign kbus.key_valid_o = valid_q;
    assign kbus.key_held_o  = held_q;

    always_ff @(posedge clock2 or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            div_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
        end else begin
            sync1_q <= kbus.row_i;
            sync2_q <= sync1_q;
            if (sample) begin
                div_q                      <= '0;
                col_q                      <= col_q + 2'd1;
                snap_q[{col_q, 2'b00} +: 4] <= ~sync2_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (merged[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        none    = (ones == 5'd0);
        single  = (ones == 5'd1);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    always_ff @(posedge clock2 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (single) begin
                        cand_d = idx;
                        if (DEBOUNCE == 1) begin
                            key_d   = idx;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_PRESSED;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (single && (idx == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_PRESSED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (none) begin
                        if (DEBOUNCE == 1) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = S_RELEASE;
                        end
                    end
                end
                default: begin
                    if (none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_PRESSED;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-by-frame check of keypad_scanner (SCAN_DIV=8, DEBOUNCE=3) against a
// behavioural key matrix and hand-computed per-frame expectations.
module tb_keypad_scanner;

    localparam int unsigned FRAME = 32;

    logic        clock2;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  row_m;
    int          checks;
    int          errors;
    int          pulses;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV (8),
        .DEBOUNCE (3)
    ) dut (
        .clock2 (clock2),
        .reset  (reset),
        .kbus   (kif)
    );

    initial begin
        clock2 = 1'b0;
        forever #5 clock2 = ~clock2;
    end

    // A closed key (c,r) pulls row r low while column c is driven low.
    always_comb begin
        row_m = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kif.col_o[c] && keys[c*4 + r]) row_m[r] = 1'b0;
    end
    assign kif.row_i = row_m;

    always @(negedge clock2) begin
        if (kif.key_valid_o === 1'b1) pulses <= pulses + 1;
    end

    typedef struct {
        logic [15:0] keys;
        logic        v;
        logic        h;
        logic [3:0]  k;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] m, input logic v, input logic h, input logic [3:0] k);
        vec_t e;
        e.keys = m;
        e.v    = v;
        e.h    = h;
        e.k    = k;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_frame(input string tag, input logic [15:0] m,
                            input logic v, input logic h, input logic [3:0] k);
        int p0;
        keys = m;
        p0   = pulses;
        repeat (FRAME) @(posedge clock2);
        @(negedge clock2);
        #1;
        chk({tag, "_valid"},  32'(kif.key_valid_o), 32'(v));
        chk({tag, "_pulses"}, 32'(pulses - p0),     32'(v));
        chk({tag, "_held"},   32'(kif.key_held_o),  32'(h));
        chk({tag, "_key"},    32'(kif.key_o),       32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] col_exp [0:3];
        checks = 0;
        errors = 0;
        pulses = 0;
        keys   = '0;
        reset  = 1'b0;

        // Single press of (2,1), then release.
        add(16'h0200, 0, 0, 4'h0);
        add(16'h0200, 0, 0, 4'h0);
        add(16'h0200, 1, 1, 4'h9);
        add(16'h0200, 0, 1, 4'h9);
        add(16'h0200, 0, 1, 4'h9);
        add(16'h0000, 0, 1, 4'h9);
        add(16'h0000, 0, 1, 4'h9);
        add(16'h0000, 0, 0, 4'h9);
        add(16'h0000, 0, 0, 4'h9);
        // Bounce on (0,3).
        for (int i = 0; i < 8; i++)
            add((i % 2 == 0) ? 16'h0008 : 16'h0000, 0, 0, 4'h9);
        // Multiple keys (1,0)+(3,2), then only (1,0).
        for (int i = 0; i < 6; i++)
            add(16'h4010, 0, 0, 4'h9);
        add(16'h0010, 0, 0, 4'h9);
        add(16'h0010, 0, 0, 4'h9);
        add(16'h0010, 1, 1, 4'h4);
        // Release bounce: open 2, close 1, open 3.
        add(16'h0000, 0, 1, 4'h4);
        add(16'h0000, 0, 1, 4'h4);
        add(16'h0010, 0, 1, 4'h4);
        add(16'h0000, 0, 1, 4'h4);
        add(16'h0000, 0, 1, 4'h4);
        add(16'h0000, 0, 0, 4'h4);
        // Press (3,3) into PRESSED ahead of the reset-while-held sequence.
        add(16'h8000, 0, 0, 4'h4);
        add(16'h8000, 0, 0, 4'h4);
        add(16'h8000, 1, 1, 4'hF);

        repeat (3) @(negedge clock2);
        #1;
        chk("rst_col",   32'(kif.col_o),       32'hE);
        chk("rst_key",   32'(kif.key_o),       32'h0);
        chk("rst_valid", 32'(kif.key_valid_o), 32'h0);
        chk("rst_held",  32'(kif.key_held_o),  32'h0);

        @(negedge clock2);
        reset = 1'b1;
        col_exp[0] = 4'hD;
        col_exp[1] = 4'hB;
        col_exp[2] = 4'h7;
        col_exp[3] = 4'hE;
        for (int i = 0; i < 4; i++) begin
            repeat (8) @(posedge clock2);
            @(negedge clock2);
            #1;
            chk($sformatf("walk%0d_col", i), 32'(kif.col_o), 32'(col_exp[i]));
        end
        chk("walk_valid", 32'(kif.key_valid_o), 32'h0);

        foreach (tbl[i])
            do_frame($sformatf("f%0d", i), tbl[i].keys, tbl[i].v, tbl[i].h, tbl[i].k);

        // Asynchronous reset mid-frame while (3,3) is still closed.
        repeat (13) @(negedge clock2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_col",   32'(kif.col_o),       32'hE);
        chk("mid_rst_key",   32'(kif.key_o),       32'h0);
        chk("mid_rst_valid", 32'(kif.key_valid_o), 32'h0);
        chk("mid_rst_held",  32'(kif.key_held_o),  32'h0);
        repeat (3) @(negedge clock2);
        reset = 1'b1;
        do_frame("rh0", 16'h8000, 0, 0, 4'h0);
        do_frame("rh1", 16'h8000, 0, 0, 4'h0);
        do_frame("rh2", 16'h8000, 1, 1, 4'hF);
        do_frame("rh3", 16'h8000, 0, 1, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
